// File: rtl/jtag_tap_bscan_if.sv
// Serial JTAG pins between the header (master) and the TAP (slave).
interface jtag_tap_bscan_if;
  logic TMS;
  logic TDI;
  logic TDO;
  logic TDO_OE;

  modport master (output TMS, output TDI, input TDO, input TDO_OE);
  modport slave  (input TMS, input TDI, output TDO, output TDO_OE);
endinterface

// File: rtl/jtag_tap_bscan.sv
// IEEE-1149.1-style TAP: 16-state controller, IR, BYPASS, IDCODE/USERCODE and an
// N_IO-pin boundary-scan register (one input and one output cell per pin).
module jtag_tap_bscan #(
  parameter int          IR_W     = 4,
  parameter int          N_IO     = 4,
  parameter logic [31:0] IDCODE   = 32'h1000_0001,
  parameter logic [31:0] USERCODE = 32'h0000_0000
) (
  input  logic              TCK,
  input  logic              TRST,
  jtag_tap_bscan_if.slave   jtag,
  input  logic [N_IO-1:0]   CORE_OUT,
  output logic [N_IO-1:0]   CORE_IN,
  input  logic [N_IO-1:0]   PIN_IN,
  output logic [N_IO-1:0]   PIN_OUT,
  output logic [N_IO-1:0]   PIN_OE,
  output logic [3:0]        TAP_STATE,
  output logic [IR_W-1:0]   IR_OUT
);

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PA_DR, ST_EX2_DR,
    ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PA_IR, ST_EX2_IR, ST_UPD_IR
  } state_t;

  localparam logic [IR_W-1:0] OP_SAMPLE   = IR_W'(1);
  localparam logic [IR_W-1:0] OP_EXTEST   = IR_W'(2);
  localparam logic [IR_W-1:0] OP_INTEST   = IR_W'(3);
  localparam logic [IR_W-1:0] OP_CLAMP    = IR_W'(5);
  localparam logic [IR_W-1:0] OP_IDCODE   = IR_W'(7);
  localparam logic [IR_W-1:0] OP_USERCODE = IR_W'(8);
  localparam logic [IR_W-1:0] OP_HIGHZ    = IR_W'(9);

  state_t              r_state;
  state_t              w_state_next;
  logic [IR_W-1:0]     r_ir;
  logic [IR_W-1:0]     r_ir_sh;
  logic                r_bypass;
  logic [31:0]         r_id_sh;
  logic [2*N_IO-1:0]   r_bsr_sh;
  logic [2*N_IO-1:0]   r_upd;
  logic [2*N_IO-1:0]   w_bsr_cap;
  logic                w_rst;
  logic                w_sel_bsr;
  logic                w_sel_id;
  logic                w_tdo;

  // A whole cycle spent in Test-Logic-Reset clears the same state as TRST.
  assign w_rst     = TRST | (r_state == ST_TLR);
  assign w_sel_bsr = (r_ir == OP_SAMPLE) | (r_ir == OP_EXTEST) | (r_ir == OP_INTEST);
  assign w_sel_id  = (r_ir == OP_IDCODE) | (r_ir == OP_USERCODE);

  // Capture vector: input cells take the pad, output cells take the core.
  generate
    for (genvar gi = 0; gi < N_IO; gi++) begin : g_cap
      assign w_bsr_cap[gi]        = PIN_IN[gi];
      assign w_bsr_cap[N_IO + gi] = CORE_OUT[gi];
    end
  endgenerate

  // TAP state register; TRST overrides TMS.
  always_ff @(posedge TCK) begin
    if (TRST) r_state <= ST_TLR;
    else      r_state <= w_state_next;
  end

  // Standard 1149.1 TMS transition table.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_TLR:    w_state_next = jtag.TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    w_state_next = jtag.TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: w_state_next = jtag.TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: w_state_next = jtag.TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  w_state_next = jtag.TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: w_state_next = jtag.TMS ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  w_state_next = jtag.TMS ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: w_state_next = jtag.TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: w_state_next = jtag.TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: w_state_next = jtag.TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: w_state_next = jtag.TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  w_state_next = jtag.TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: w_state_next = jtag.TMS ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  w_state_next = jtag.TMS ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: w_state_next = jtag.TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: w_state_next = jtag.TMS ? ST_SEL_DR : ST_RTI;
      default:   w_state_next = ST_TLR;
    endcase
  end

  // Instruction register: capture 0..01, shift toward TDO, commit on UPD_IR.
  always_ff @(posedge TCK) begin
    if (w_rst) begin
      r_ir    <= OP_IDCODE;
      r_ir_sh <= '0;
    end else begin
      case (r_state)
        ST_CAP_IR: r_ir_sh <= IR_W'(2'b01);
        ST_SH_IR:  r_ir_sh <= {jtag.TDI, r_ir_sh[IR_W-1:1]};
        ST_UPD_IR: r_ir    <= r_ir_sh;
        default:   ;
      endcase
    end
  end

  // Data registers: only the DR selected by the active instruction moves.
  always_ff @(posedge TCK) begin
    if (w_rst) begin
      r_bypass <= 1'b0;
      r_id_sh  <= '0;
      r_bsr_sh <= '0;
      r_upd    <= '0;
    end else begin
      case (r_state)
        ST_CAP_DR: begin
          if (w_sel_bsr)     r_bsr_sh <= w_bsr_cap;
          else if (w_sel_id) r_id_sh  <= (r_ir == OP_IDCODE) ? IDCODE : USERCODE;
          else               r_bypass <= 1'b0;
        end
        ST_SH_DR: begin
          if (w_sel_bsr)     r_bsr_sh <= {jtag.TDI, r_bsr_sh[2*N_IO-1:1]};
          else if (w_sel_id) r_id_sh  <= {jtag.TDI, r_id_sh[31:1]};
          else               r_bypass <= jtag.TDI;
        end
        ST_UPD_DR: begin
          if (w_sel_bsr) r_upd <= r_bsr_sh;
        end
        default: ;
      endcase
    end
  end

  // TDO mux: LSB of whichever register is shifting, quiet otherwise.
  always_comb begin
    w_tdo = 1'b0;
    if (r_state == ST_SH_IR) begin
      w_tdo = r_ir_sh[0];
    end else if (r_state == ST_SH_DR) begin
      if (w_sel_bsr)     w_tdo = r_bsr_sh[0];
      else if (w_sel_id) w_tdo = r_id_sh[0];
      else               w_tdo = r_bypass;
    end
  end

  assign jtag.TDO    = w_tdo;
  assign jtag.TDO_OE = (r_state == ST_SH_DR) | (r_state == ST_SH_IR);
  assign TAP_STATE   = r_state;
  assign IR_OUT      = r_ir;

  // Pad muxing; SAMPLE leaves the functional paths untouched.
  assign PIN_OUT = ((r_ir == OP_EXTEST) | (r_ir == OP_CLAMP)) ? r_upd[2*N_IO-1:N_IO] : CORE_OUT;
  assign PIN_OE  = (r_ir == OP_HIGHZ) ? '0 : '1;
  assign CORE_IN = (r_ir == OP_INTEST) ? r_upd[N_IO-1:0] : PIN_IN;

endmodule

// File: tb/tb_jtag_tap_bscan.sv
// Directed bench for jtag_tap_bscan: instruction/DR vector table plus reset,
// pause and TLR corner sequences.
module tb_jtag_tap_bscan;
  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic [3:0] CORE_OUT = 4'h0;
  logic [3:0] PIN_IN = 4'h0;
  logic [3:0] CORE_IN, PIN_OUT, PIN_OE, TAP_STATE, IR_OUT;
  int         n_checks = 0;
  int         n_errors = 0;

  jtag_tap_bscan_if jtag ();

  jtag_tap_bscan #(
    .IR_W(4), .N_IO(4), .IDCODE(32'h1000_0001), .USERCODE(32'h0000_0000)
  ) dut (
    .TCK(TCK), .TRST(TRST), .jtag(jtag.slave),
    .CORE_OUT(CORE_OUT), .CORE_IN(CORE_IN), .PIN_IN(PIN_IN), .PIN_OUT(PIN_OUT),
    .PIN_OE(PIN_OE), .TAP_STATE(TAP_STATE), .IR_OUT(IR_OUT)
  );

  always #5 TCK = ~TCK;

  typedef struct {
    logic [3:0]  op;
    int          len;
    logic [31:0] din;
    logic [31:0] dout;
    logic [3:0]  pin_in;
    logic [3:0]  core_out;
    logic [3:0]  pin_out;
    logic [3:0]  core_in;
    logic [3:0]  pin_oe;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic tms, input logic tdi);
    jtag.TMS = tms;
    jtag.TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // Must be called in a shift state; leaves the TAP in Exit1.
  task automatic shift_bits(input int len, input logic [31:0] din, output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < len; i++) begin
      dout[i] = jtag.TDO;
      step(i == len - 1, din[i]);
    end
  endtask

  task automatic goto_sh_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RTI: load an instruction and return to RTI, reporting the captured IR.
  task automatic load_ir(input logic [3:0] op, output logic [31:0] cap);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(4, {28'h0, op}, cap);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] d1, d2, cap, dout;

    //              op    len din           dout          pin  core pout cin  oe
    vecs[0] = '{4'h7, 32, 32'h0000_0000, 32'h1000_0001, 4'h3, 4'hC, 4'hC, 4'h3, 4'hF};
    vecs[1] = '{4'hF,  9, 32'h0000_00A5, 32'h0000_014A, 4'h1, 4'h2, 4'h2, 4'h1, 4'hF};
    vecs[2] = '{4'h1,  8, 32'h0000_0000, 32'h0000_0096, 4'h6, 4'h9, 4'h9, 4'h6, 4'hF};
    vecs[3] = '{4'h2,  8, 32'h0000_00A0, 32'h0000_0005, 4'h5, 4'h0, 4'hA, 4'h5, 4'hF};
    vecs[4] = '{4'h3,  8, 32'h0000_005C, 32'h0000_003F, 4'hF, 4'h3, 4'h3, 4'hC, 4'hF};
    vecs[5] = '{4'h5,  2, 32'h0000_0001, 32'h0000_0002, 4'h2, 4'h8, 4'h5, 4'h2, 4'hF};
    vecs[6] = '{4'h9,  3, 32'h0000_0006, 32'h0000_0004, 4'hA, 4'h7, 4'h7, 4'hA, 4'h0};
    vecs[7] = '{4'h8, 32, 32'hDEAD_BEEF, 32'h0000_0000, 4'h4, 4'h4, 4'h4, 4'h4, 4'hF};
    vecs[8] = '{4'h4,  4, 32'h0000_000B, 32'h0000_0006, 4'h1, 4'hE, 4'hE, 4'h1, 4'hF};
    vecs[9] = '{4'h2,  8, 32'h0000_0031, 32'h0000_00F0, 4'h0, 4'hF, 4'h3, 4'h0, 4'hF};

    jtag.TMS = 1'b0;
    jtag.TDI = 1'b0;

    // Reset: TMS=0 is ignored while TRST is high, so the TAP stays in TLR.
    TRST = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_state", 32'(TAP_STATE), 32'h0);
    chk("rst_ir", 32'(IR_OUT), 32'h7);
    chk("rst_pin_oe", 32'(PIN_OE), 32'hF);
    chk("rst_tdo_oe", 32'(jtag.TDO_OE), 32'h0);
    chk("rst_tdo", 32'(jtag.TDO), 32'h0);
    $display("reset state=%h ir=%h", TAP_STATE, IR_OUT);
    TRST = 1'b0;

    // IDCODE after reset: TMS 0,1,0,0 then 32 shifts.
    step(1'b0, 1'b0);
    goto_sh_dr();
    chk("idc_state", 32'(TAP_STATE), 32'h4);
    chk("idc_tdo_oe", 32'(jtag.TDO_OE), 32'h1);
    shift_bits(32, 32'h0, dout);
    chk("idc_dout", dout, 32'h1000_0001);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    $display("idcode dout=%h", dout);

    // IR commit timing: IR_OUT unchanged while in UPD_IR, new value afterwards.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(4, 32'hF, cap);
    chk("irt_cap", cap, 32'h1);
    step(1'b1, 1'b0);
    chk("irt_upd_state", 32'(TAP_STATE), 32'hF);
    chk("irt_ir_old", 32'(IR_OUT), 32'h7);
    step(1'b0, 1'b0);
    chk("irt_ir_new", 32'(IR_OUT), 32'hF);
    $display("ir_timing cap=%h ir=%h", cap, IR_OUT);

    // Table: load IR, shift DR, update, check pad muxing.
    for (int r = 0; r < 10; r++) begin
      PIN_IN   = vecs[r].pin_in;
      CORE_OUT = vecs[r].core_out;
      load_ir(vecs[r].op, cap);
      chk($sformatf("v%0d_ir_cap", r), cap, 32'h1);
      chk($sformatf("v%0d_ir_out", r), 32'(IR_OUT), 32'(vecs[r].op));
      goto_sh_dr();
      shift_bits(vecs[r].len, vecs[r].din, dout);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk($sformatf("v%0d_dout", r), dout, vecs[r].dout);
      chk($sformatf("v%0d_pin_out", r), 32'(PIN_OUT), 32'(vecs[r].pin_out));
      chk($sformatf("v%0d_core_in", r), 32'(CORE_IN), 32'(vecs[r].core_in));
      chk($sformatf("v%0d_pin_oe", r), 32'(PIN_OE), 32'(vecs[r].pin_oe));
      chk($sformatf("v%0d_state", r), 32'(TAP_STATE), 32'h1);
      $display("vec %0d op=%h dout=%h pin_out=%h core_in=%h pin_oe=%h",
               r, vecs[r].op, dout, PIN_OUT, CORE_IN, PIN_OE);
    end

    // Pause mid-shift must hold the IDCODE shift contents.
    TRST = 1'b1;
    step(1'b0, 1'b0);
    TRST = 1'b0;
    step(1'b0, 1'b0);
    goto_sh_dr();
    shift_bits(4, 32'h0, d1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pause_state", 32'(TAP_STATE), 32'h6);
    chk("pause_tdo_oe", 32'(jtag.TDO_OE), 32'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("pause_resume_state", 32'(TAP_STATE), 32'h4);
    shift_bits(28, 32'h0, d2);
    chk("pause_dout", {d2[27:0], d1[3:0]}, 32'h1000_0001);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    $display("pause dout=%h", {d2[27:0], d1[3:0]});

    // Five TMS=1 reach TLR; a full cycle there restores IDCODE.
    load_ir(4'hF, cap);
    goto_sh_dr();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tms5_state", 32'(TAP_STATE), 32'h0);
    step(1'b1, 1'b0);
    chk("tms5_ir", 32'(IR_OUT), 32'h7);
    $display("tms5 state=%h ir=%h", TAP_STATE, IR_OUT);

    // HIGHZ, then TRST asserted in SH_DR.
    step(1'b0, 1'b0);
    load_ir(4'h9, cap);
    chk("hz_pin_oe", 32'(PIN_OE), 32'h0);
    goto_sh_dr();
    chk("hz_tdo_oe", 32'(jtag.TDO_OE), 32'h1);
    TRST = 1'b1;
    step(1'b0, 1'b1);
    chk("hz_rst_state", 32'(TAP_STATE), 32'h0);
    chk("hz_rst_ir", 32'(IR_OUT), 32'h7);
    chk("hz_rst_pin_oe", 32'(PIN_OE), 32'hF);
    chk("hz_rst_tdo_oe", 32'(jtag.TDO_OE), 32'h0);
    TRST = 1'b0;
    $display("highz_reset state=%h ir=%h pin_oe=%h", TAP_STATE, IR_OUT, PIN_OE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
